stack_alu_sequencer: RTL
========================

// Module: stack_alu_sequencer
// PURPOSE
//  Multi-cycle controller that executes one stack instruction per start pulse.
//  Pops operands from the stack RAM, drives the 2-bit-select ALU, and pushes the result back.
//  Owns the stack pointer (SP). Sits between the processor main control FSM and the ALU / stack RAM.
// PARAMETERS
//  DATA_W  5  operand/result width, matches ALU Ain/Bin/AluOut
//  ADDR_W  3  stack RAM address width; DEPTH = 2**ADDR_W entries
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  start      in   1         request; sampled only in IDLE
//  op         in   3         000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 11x illegal
//  imm        in   DATA_W    PUSH operand, sampled with start
//  busy       out  1         high from the cycle after acceptance until DONE inclusive
//  done       out  1         1-cycle pulse, last cycle of the instruction
//  err        out  1         valid with done: underflow, overflow or illegal op
//  pop_data   out  DATA_W    value removed by POP; held until the next POP
//  sp         out  ADDR_W+1  entries on the stack (0..DEPTH)
//  alu_sl     out  2         ALU select; equals op[1:0] of the current instruction
//  alu_a      out  DATA_W    ALU Ain (registered)
//  alu_b      out  DATA_W    ALU Bin (registered)
//  alu_y      in   DATA_W    ALU AluOut (combinational)
//  mem_addr   out  ADDR_W    stack RAM address; read is combinational, write is synchronous
//  mem_we     out  1         stack RAM write enable
//  mem_wdata  out  DATA_W    stack RAM write data
//  mem_rdata  in   DATA_W    stack RAM read data for mem_addr, same cycle
// BEHAVIOUR
//  Reset values:
//   - All outputs and registers are 0; state = IDLE; sp = 0.
//   - Reset mid-instruction aborts the instruction; no RAM write occurs after reset assertion.
//  Stack layout:
//   - Stack grows upward; SP is the next free slot; top of stack = mem[sp-1].
//  FSM states: IDLE, RD_B, RD_A, EXEC, WR, DONE.
//  Acceptance (start=1 in IDLE):
//   - Latch op/imm and check legality.
//   - Binary ops (ADD/SUB/AND) need sp>=2; NOT and POP need sp>=1; PUSH needs sp<DEPTH.
//   - On violation or illegal op: go to DONE with err=1; SP and RAM are unchanged.
//  Sequences:
//   - ADD/SUB/AND: IDLE->RD_B->RD_A->EXEC->WR->DONE. done is high 5 cycles after the start cycle.
//     - RD_B: addr = sp-1, alu_b <= mem_rdata.
//     - RD_A: addr = sp-2, alu_a <= mem_rdata.
//     - EXEC: result register <= alu_y.
//     - WR: addr = sp-2, we=1, wdata = result; sp <= sp-1.
//     - Arithmetic wraps modulo 2**DATA_W; there is no carry or borrow flag.
//   - NOT: IDLE->RD_B->EXEC->WR->DONE. Write goes to sp-1; sp is unchanged; alu_a is don't-care.
//   - PUSH: IDLE->WR->DONE. WR: addr = sp, wdata = imm; sp <= sp+1.
//   - POP: IDLE->RD_B->DONE. RD_B: pop_data <= mem_rdata; sp <= sp-1.
//  Handshake:
//   - DONE always returns to IDLE.
//   - start while busy is ignored (not queued).
//   - A new start is accepted the cycle after done.
//  Other rules:
//   - mem_we is high only in WR.
//   - mem_addr is 0 in IDLE and DONE.
//   - alu_sl is held stable from acceptance through WR.
//   - SP never wraps: 0 and DEPTH are guarded by the legality check.
// STRUCTURE
//  Package stack_alu_pkg:
//   - opcode localparams (OP_ADD..OP_POP)
//   - ALU select constants (SL_ADD=00, SL_SUB=01, SL_AND=10, SL_NOT=11)
//   - FSM state encoding
//  Sub-module stack_sp_unit:
//   - SP register with inc/dec controls
//   - empty / has-two / full flags feeding the legality check
//  Remaining logic: FSM plus operand/result registers, in this module.
// TESTING
//  1. Reset, then PUSH 3 and PUSH 9 -> each done after 2 cycles; sp=2; mem[0]=3, mem[1]=9.
//  2. From test 1 state, ADD -> done 5 cycles after start; mem[0]=12; sp=1; err=0.
//  3. With stack [4,7] (top 7), SUB -> mem[0]=29 (4-7 mod 32); then NOT -> mem[0]=2.
//  4. sp=1, ADD -> done next cycle, err=1, sp=1, mem_we never asserted.
//     Also: sp=8, PUSH -> err=1. Also: op=110 -> err=1.
//  5. With stack [5], POP -> pop_data=5, sp=0, done 2 cycles after start.
//     Then POP -> err=1.
//  6. Assert rst_n low during EXEC of an ADD -> sp=0, busy=0, no write.
//     Also: start asserted while busy is ignored.

Source files
------------

// File: rtl/stack_alu_sequencer_pkg.sv
// Shared constants for the stack ALU sequencer: opcodes, ALU selects, FSM states.
package stack_alu_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned SL_W = 2;
  localparam int unsigned ST_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b011;
  localparam logic [OP_W-1:0] OP_PUSH = 3'b100;
  localparam logic [OP_W-1:0] OP_POP  = 3'b101;

  localparam logic [SL_W-1:0] SL_ADD = 2'b00;
  localparam logic [SL_W-1:0] SL_SUB = 2'b01;
  localparam logic [SL_W-1:0] SL_AND = 2'b10;
  localparam logic [SL_W-1:0] SL_NOT = 2'b11;

  localparam logic [ST_W-1:0] S_IDLE = 3'd0;
  localparam logic [ST_W-1:0] S_RD_B = 3'd1;
  localparam logic [ST_W-1:0] S_RD_A = 3'd2;
  localparam logic [ST_W-1:0] S_EXEC = 3'd3;
  localparam logic [ST_W-1:0] S_WR   = 3'd4;
  localparam logic [ST_W-1:0] S_DONE = 3'd5;

  // Two-operand instructions that consume two entries and leave one.
  function automatic logic is_binary(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Instruction handshake between the main control FSM (master) and the sequencer (slave).
interface stack_alu_sequencer_if #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] imm;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] pop_data;
  logic [ADDR_W:0]   sp;

  modport master (
    output start, op, imm,
    input  busy, done, err, pop_data, sp
  );

  modport slave (
    input  start, op, imm,
    output busy, done, err, pop_data, sp
  );
endinterface

// File: rtl/stack_sp_unit.sv
// Stack pointer register with occupancy flags used by the legality check.
module stack_sp_unit #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            dec,
  output logic [ADDR_W:0] sp,
  output logic            empty_c,
  output logic            has_two_c,
  output logic            full_c
);

  localparam int unsigned SP_W = ADDR_W + 1;
  localparam logic [SP_W-1:0] DEPTH = SP_W'(1 << ADDR_W);

  // Count entries; increments and decrements never overlap in practice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (inc && !dec) begin
      sp <= sp + SP_W'(1);
    end else if (dec && !inc) begin
      sp <= sp - SP_W'(1);
    end
  end

  // Occupancy flags.
  always_comb begin
    empty_c   = (sp == '0);
    has_two_c = (sp >= SP_W'(2));
    full_c    = (sp == DEPTH);
  end

endmodule

// File: rtl/stack_alu_sequencer.sv
// Multi-cycle stack instruction sequencer: pops operands, drives the ALU, pushes results.
module stack_alu_sequencer
  import stack_alu_pkg::*;
#(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stack_alu_sequencer_if.slave bus,
  output logic [SL_W-1:0]      alu_sl,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  input  logic [DATA_W-1:0]    alu_y,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata
);

  localparam int unsigned SP_W = ADDR_W + 1;

  logic [ST_W-1:0]   state_q, state_d;
  logic [OP_W-1:0]   op_q, op_cur_c;
  logic [DATA_W-1:0] res_q, pop_q, alu_a_q, alu_b_q;
  logic [SL_W-1:0]   alu_sl_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, busy_q, done_q, err_q;
  logic              accept_c, illegal_c;
  logic              sp_inc_c, sp_dec_c;
  logic [SP_W-1:0]   sp;
  logic              empty_c, has_two_c, full_c;

  stack_sp_unit #(.ADDR_W(ADDR_W)) u_sp (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (sp_inc_c),
    .dec       (sp_dec_c),
    .sp        (sp),
    .empty_c   (empty_c),
    .has_two_c (has_two_c),
    .full_c    (full_c)
  );

  // Legality of the request currently on the bus.
  always_comb begin
    illegal_c = 1'b1;
    case (bus.op)
      OP_ADD, OP_SUB, OP_AND: illegal_c = !has_two_c;
      OP_NOT, OP_POP:         illegal_c = empty_c;
      OP_PUSH:                illegal_c = full_c;
      default:                illegal_c = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, SP controls and the address the RAM will see next cycle.
  always_comb begin
    state_d  = state_q;
    accept_c = (state_q == S_IDLE) && bus.start;
    op_cur_c = (state_q == S_IDLE) ? bus.op : op_q;
    sp_inc_c = (state_q == S_WR) && (op_q == OP_PUSH);
    sp_dec_c = ((state_q == S_WR) && is_binary(op_q)) ||
               ((state_q == S_RD_B) && (op_q == OP_POP));
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (illegal_c)              state_d = S_DONE;
          else if (bus.op == OP_PUSH) state_d = S_WR;
          else                        state_d = S_RD_B;
        end
      end
      S_RD_B: begin
        if (op_q == OP_POP)      state_d = S_DONE;
        else if (op_q == OP_NOT) state_d = S_EXEC;
        else                     state_d = S_RD_A;
      end
      S_RD_A:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WR;
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // SP is stable across every transition into a state that addresses the RAM.
    addr_d = '0;
    case (state_d)
      S_RD_B: addr_d = ADDR_W'(sp - SP_W'(1));
      S_RD_A: addr_d = ADDR_W'(sp - SP_W'(2));
      S_WR: begin
        if (op_cur_c == OP_PUSH)     addr_d = ADDR_W'(sp);
        else if (op_cur_c == OP_NOT) addr_d = ADDR_W'(sp - SP_W'(1));
        else                         addr_d = ADDR_W'(sp - SP_W'(2));
      end
      default: addr_d = '0;
    endcase
  end

  // Registered handshake, RAM controls, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      op_q     <= '0;
      alu_sl_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      res_q    <= '0;
      pop_q    <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
      err_q  <= accept_c && illegal_c;
      addr_q <= addr_d;
      we_q   <= (state_d == S_WR);
      if (accept_c) begin
        op_q     <= bus.op;
        alu_sl_q <= bus.op[SL_W-1:0];
        if (bus.op == OP_PUSH) res_q <= bus.imm;
      end
      if (state_q == S_RD_B) begin
        if (op_q == OP_POP) pop_q   <= mem_rdata;
        else                alu_b_q <= mem_rdata;
      end
      if (state_q == S_RD_A) alu_a_q <= mem_rdata;
      if (state_q == S_EXEC) res_q   <= alu_y;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.pop_data = pop_q;
  assign bus.sp       = sp;
  assign alu_sl       = alu_sl_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign mem_addr     = addr_q;
  assign mem_we       = we_q;
  assign mem_wdata    = res_q;

endmodule
